// File: rtl/scan_test_sched.sv
// Scan-chain scheduler: the TAP path owns the chain by default; the BIST engine can borrow it
// to shift LFSR patterns, pulse capture and compact the chain output into a 16-bit MISR.
module scan_test_sched #(
    parameter int CHAIN_LEN = 32
) (
    input  logic        tck,
    input  logic        trst,
    input  logic        tap_shift,
    input  logic        tap_test,
    input  logic        tap_sin,
    input  logic        sout,
    output logic        shift,
    output logic        test,
    output logic        sin,
    output logic        tap_owner,
    input  logic        bist_start,
    input  logic [7:0]  bist_patterns,
    input  logic [15:0] bist_seed,
    output logic        bist_busy,
    output logic        bist_done,
    output logic        bist_abort,
    output logic [15:0] bist_signature,
    output logic [2:0]  dbg_state
);

    localparam int              CW       = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0]   LAST     = CW'(CHAIN_LEN - 1);
    localparam logic [15:0]     DEF_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    count_q, count_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   misr_q, misr_d;
    logic          first_q, first_d;
    logic          abort_q, abort_d;
    logic          engine;
    logic          misr_en;
    logic [7:0]    count_dec;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            lfsr_q  <= DEF_SEED;
            misr_q  <= '0;
            first_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            first_q <= first_d;
            abort_q <= abort_d;
        end
    end

    assign engine = (state_q == S_LOAD) || (state_q == S_CAPTURE) || (state_q == S_UNLOAD);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        first_d   = first_q;
        abort_d   = 1'b0;
        misr_en   = 1'b0;
        count_dec = count_q - 8'd1;
        shift     = tap_shift;
        test      = tap_test;
        sin       = tap_sin;

        case (state_q)
            S_IDLE: begin
                if (bist_start && !tap_test) begin
                    count_d = bist_patterns;
                    misr_d  = '0;
                    lfsr_d  = (bist_seed == '0) ? DEF_SEED : bist_seed;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = (bist_patterns == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                shift  = 1'b1;
                test   = 1'b1;
                sin    = lfsr_q[15];
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                // Chain content before the first load is unknown, so keep it out of the signature.
                misr_en = !first_q;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                shift   = 1'b0;
                test    = 1'b1;
                sin     = 1'b0;
                count_d = count_dec;
                first_d = 1'b0;
                state_d = (count_dec != '0) ? S_LOAD : S_UNLOAD;
            end
            S_UNLOAD: begin
                shift   = 1'b1;
                test    = 1'b1;
                sin     = 1'b0;
                misr_en = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (misr_en) begin
            misr_d = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10] ^ sout};
        end

        // TAP preemption wins over any engine transition; the partial signature is kept.
        if (engine && tap_test) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            abort_d = 1'b1;
        end
    end

    assign bist_busy      = engine;
    assign tap_owner      = ~engine;
    assign bist_done      = (state_q == S_DONE);
    assign bist_abort     = abort_q;
    assign bist_signature = misr_q;
    assign dbg_state      = state_q;

endmodule
